// File: rtl/round_timer_pkg.sv
// Shared definitions for the round countdown timer: FSM encoding,
// the largest displayable count and the BCD load clamp.
package round_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_SECS = 99;

  // Clamp each BCD nibble to 9 and return the binary seconds value (0..99).
  function automatic logic [6:0] bcd_clamp_to_bin(input logic [7:0] bcd);
    logic [3:0] t;
    logic [3:0] o;
    t = (bcd[7:4] > 4'd9) ? 4'd9 : bcd[7:4];
    o = (bcd[3:0] > 4'd9) ? 4'd9 : bcd[3:0];
    return 7'(t) * 7'd10 + 7'(o);
  endfunction

endpackage

// File: rtl/round_timer_ctrl_bin_to_bcd2.sv
// Combinational 7-bit binary to two BCD digits; valid for inputs 0..99.
module bin_to_bcd2 (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // Find the largest multiple of ten not above the input, remainder is ones.
  always_comb begin
    tens_o = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (bin_i >= 7'(i * 10)) tens_o = 4'(i);
    end
    ones_o = 4'(bin_i - 7'(tens_o) * 7'd10);
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round countdown controller: loads a BCD start value, counts down once per
// TICK_DIV cycles, supports pause/resume and hit penalties, and pulses
// expired on entry to DONE. The FSM state is exposed on the state port.
module round_timer_ctrl
  import round_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int PENALTY  = 5
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic [7:0] load_bcd,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic [1:0] state
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    DEC_HIT    = 7'(PENALTY);
  localparam logic [6:0]    DEC_BOTH   = 7'(PENALTY + 1);

  state_t        state_q, state_d;
  logic [6:0]    secs_q, secs_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          paused_q, paused_d;
  logic          expired_q, expired_d;

  logic [6:0]    load_secs;
  logic          tick;
  logic [6:0]    dec;
  logic [6:0]    sub_res;

  // Tick detection, decrement amount and saturating subtraction.
  always_comb begin
    load_secs = bcd_clamp_to_bin(load_bcd);
    tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    if (tick && hit)  dec = DEC_BOTH;
    else if (hit)     dec = DEC_HIT;
    else if (tick)    dec = 7'd1;
    else              dec = 7'd0;
    if (secs_q <= dec) sub_res = 7'd0;
    else               sub_res = secs_q - dec;
  end

  // Next-state logic; start beats pause, pause beats tick/hit.
  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    if (start) begin
      secs_d  = load_secs;
      presc_d = '0;
      if (load_secs == 7'd0) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (pause) begin
      // Prescaler is left untouched so a paused interval resumes where it stopped.
      if (state_q == ST_RUN)        state_d = ST_PAUSE;
      else if (state_q == ST_PAUSE) state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (dec != 7'd0) begin
        secs_d = sub_res;
        if (sub_res == 7'd0) begin
          state_d   = ST_DONE;
          expired_d = 1'b1;
        end
      end
    end
    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
  end

  // State, count, prescaler and registered status flags.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      secs_q    <= 7'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      paused_q  <= paused_d;
      expired_q <= expired_d;
    end
  end

  bin_to_bcd2 u_bcd (
    .bin_i  (secs_q),
    .tens_o (tens),
    .ones_o (ones)
  );

  assign running = running_q;
  assign paused  = paused_q;
  assign expired = expired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with TICK_DIV=4, PENALTY=5.
module tb_round_timer_ctrl;

  logic       CLOCK_50;
  logic       resetn;
  logic       start;
  logic       pause;
  logic       hit;
  logic [7:0] load_bcd;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       paused;
  logic       expired;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rstn;
    logic       st;
    logic       pa;
    logic       hi;
    logic [7:0] ld;
    int         edges;
    logic [3:0] e_tens;
    logic [3:0] e_ones;
    logic [1:0] e_state;
    logic       e_run;
    logic       e_pau;
    logic       e_exp;
  } vec_t;

  vec_t tbl[40];
  int   n_vec = 0;

  round_timer_ctrl #(.TICK_DIV(4), .PENALTY(5)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (start),
    .pause    (pause),
    .hit      (hit),
    .load_bcd (load_bcd),
    .tens     (tens),
    .ones     (ones),
    .running  (running),
    .paused   (paused),
    .expired  (expired),
    .state    (state)
  );

  // Clock and initial input levels.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic add_vec(input logic rstn, input logic st, input logic pa, input logic hi,
                         input logic [7:0] ld, input int edges,
                         input logic [3:0] et, input logic [3:0] eo, input logic [1:0] es,
                         input logic er, input logic ep, input logic ee);
    tbl[n_vec].rstn    = rstn;
    tbl[n_vec].st      = st;
    tbl[n_vec].pa      = pa;
    tbl[n_vec].hi      = hi;
    tbl[n_vec].ld      = ld;
    tbl[n_vec].edges   = edges;
    tbl[n_vec].e_tens  = et;
    tbl[n_vec].e_ones  = eo;
    tbl[n_vec].e_state = es;
    tbl[n_vec].e_run   = er;
    tbl[n_vec].e_pau   = ep;
    tbl[n_vec].e_exp   = ee;
    n_vec++;
  endtask

  // Scoreboard compare of the full output bundle.
  task automatic check_out(input string name, input logic [3:0] et, input logic [3:0] eo,
                           input logic [1:0] es, input logic er, input logic ep, input logic ee);
    total++;
    if ({tens, ones, state, running, paused, expired} !== {et, eo, es, er, ep, ee}) begin
      bad++;
      $display("FAIL %s: got digits=%h/%h state=%0d run=%b pau=%b exp=%b, want digits=%h/%h state=%0d run=%b pau=%b exp=%b",
               name, tens, ones, state, running, paused, expired, et, eo, es, er, ep, ee);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Driver: present one row's pulses for one edge, idle for the rest, then compare.
  task automatic apply_vec(input int idx);
    string nm;
    resetn   = tbl[idx].rstn;
    start    = tbl[idx].st;
    pause    = tbl[idx].pa;
    hit      = tbl[idx].hi;
    load_bcd = tbl[idx].ld;
    for (int e = 0; e < tbl[idx].edges; e++) begin
      @(posedge CLOCK_50);
      #1;
      resetn = 1'b1;
      start  = 1'b0;
      pause  = 1'b0;
      hit    = 1'b0;
    end
    nm = $sformatf("row%0d", idx);
    check_out(nm, tbl[idx].e_tens, tbl[idx].e_ones, tbl[idx].e_state,
              tbl[idx].e_run, tbl[idx].e_pau, tbl[idx].e_exp);
  endtask

  initial begin
    int exp_cnt;
    int exp_at;

    resetn   = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    hit      = 1'b0;
    load_bcd = 8'h00;

    //       rstn st pa hi load  edges tens ones st run pau exp
    add_vec(1'b0, 0, 0, 0, 8'h00, 1, 4'd0, 4'd0, 2'd0, 0, 0, 0); // 0 reset
    add_vec(1'b1, 1, 0, 0, 8'h12, 1, 4'd1, 4'd2, 2'd1, 1, 0, 0); // 1 start 12
    add_vec(1'b1, 0, 0, 0, 8'h00, 4, 4'd1, 4'd1, 2'd1, 1, 0, 0); // 2 first tick
    add_vec(1'b1, 0, 0, 0, 8'h00, 4, 4'd1, 4'd0, 2'd1, 1, 0, 0); // 3
    add_vec(1'b1, 0, 0, 0, 8'h00, 4, 4'd0, 4'd9, 2'd1, 1, 0, 0); // 4
    // hand sequence runs between row 4 and row 5
    add_vec(1'b1, 1, 0, 0, 8'h07, 1, 4'd0, 4'd7, 2'd1, 1, 0, 0); // 5 start 07 from DONE
    add_vec(1'b1, 0, 0, 1, 8'h00, 1, 4'd0, 4'd2, 2'd1, 1, 0, 0); // 6 hit
    add_vec(1'b1, 0, 0, 1, 8'h00, 1, 4'd0, 4'd0, 2'd3, 0, 0, 1); // 7 hit saturates
    add_vec(1'b1, 0, 0, 0, 8'h00, 1, 4'd0, 4'd0, 2'd3, 0, 0, 0); // 8 expired one cycle
    add_vec(1'b1, 0, 0, 1, 8'h00, 1, 4'd0, 4'd0, 2'd3, 0, 0, 0); // 9 hit in DONE
    add_vec(1'b1, 1, 0, 0, 8'h20, 1, 4'd2, 4'd0, 2'd1, 1, 0, 0); // 10 start 20
    add_vec(1'b1, 0, 0, 0, 8'h00, 3, 4'd2, 4'd0, 2'd1, 1, 0, 0); // 11 up to tick cycle
    add_vec(1'b1, 0, 0, 1, 8'h00, 1, 4'd1, 4'd4, 2'd1, 1, 0, 0); // 12 hit+tick -> 14
    add_vec(1'b1, 0, 0, 0, 8'h00, 2, 4'd1, 4'd4, 2'd1, 1, 0, 0); // 13 two cycles in
    add_vec(1'b1, 0, 1, 0, 8'h00, 1, 4'd1, 4'd4, 2'd2, 0, 1, 0); // 14 pause
    add_vec(1'b1, 0, 0, 1, 8'h00, 1, 4'd1, 4'd4, 2'd2, 0, 1, 0); // 15 hit in PAUSE
    add_vec(1'b1, 0, 0, 0, 8'h00, 9, 4'd1, 4'd4, 2'd2, 0, 1, 0); // 16 hold
    add_vec(1'b1, 0, 1, 0, 8'h00, 1, 4'd1, 4'd4, 2'd1, 1, 0, 0); // 17 resume
    add_vec(1'b1, 0, 0, 0, 8'h00, 1, 4'd1, 4'd4, 2'd1, 1, 0, 0); // 18 one RUN cycle
    add_vec(1'b1, 0, 0, 0, 8'h00, 1, 4'd1, 4'd3, 2'd1, 1, 0, 0); // 19 second RUN cycle ticks
    add_vec(1'b1, 1, 0, 0, 8'hFA, 1, 4'd9, 4'd9, 2'd1, 1, 0, 0); // 20 clamp FA -> 99
    add_vec(1'b1, 1, 0, 0, 8'h00, 1, 4'd0, 4'd0, 2'd3, 0, 0, 1); // 21 zero load
    add_vec(1'b1, 0, 0, 0, 8'h00, 1, 4'd0, 4'd0, 2'd3, 0, 0, 0); // 22
    add_vec(1'b1, 1, 0, 0, 8'h35, 1, 4'd3, 4'd5, 2'd1, 1, 0, 0); // 23 start in DONE
    add_vec(1'b1, 0, 0, 0, 8'h00, 2, 4'd3, 4'd5, 2'd1, 1, 0, 0); // 24
    add_vec(1'b0, 0, 0, 0, 8'h00, 1, 4'd0, 4'd0, 2'd0, 0, 0, 0); // 25 reset mid-RUN
    add_vec(1'b1, 0, 0, 0, 8'h00, 1, 4'd0, 4'd0, 2'd0, 0, 0, 0); // 26 IDLE holds
    add_vec(1'b1, 0, 1, 0, 8'h00, 1, 4'd0, 4'd0, 2'd0, 0, 0, 0); // 27 pause in IDLE
    add_vec(1'b1, 0, 0, 1, 8'h00, 1, 4'd0, 4'd0, 2'd0, 0, 0, 0); // 28 hit in IDLE
    add_vec(1'b1, 1, 0, 0, 8'h3C, 1, 4'd3, 4'd9, 2'd1, 1, 0, 0); // 29 ones clamp
    add_vec(1'b1, 1, 0, 0, 8'h45, 1, 4'd4, 4'd5, 2'd1, 1, 0, 0); // 30 restart in RUN
    add_vec(1'b1, 0, 0, 0, 8'h00, 3, 4'd4, 4'd5, 2'd1, 1, 0, 0); // 31 prescaler restarted
    add_vec(1'b1, 0, 0, 0, 8'h00, 1, 4'd4, 4'd4, 2'd1, 1, 0, 0); // 32

    for (int i = 0; i <= 4; i++) apply_vec(i);

    // Hand sequence: remaining 9 seconds run out 36 cycles later, one expired pulse.
    exp_cnt = 0;
    exp_at  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (expired) begin
        exp_cnt++;
        exp_at = i;
      end
      if (i == 35) check_out("before_zero", 4'd0, 4'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      if (i == 36) check_out("at_zero", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    end
    check_int("expired_count", exp_cnt, 1);
    check_int("expired_cycle", exp_at, 36);
    check_out("done_hold", 4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0);

    for (int i = 5; i < n_vec; i++) apply_vec(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
